// File: rtl/dma_io_peripheral.sv
// DMA requester on one DREQ/DACK channel: bytes move through an internal FIFO
// between the DMA bus strobes and a local valid/ready stream.
module dma_io_peripheral #(
    parameter int CHANNEL = 0,
    parameter int DEPTH   = 8,
    parameter int DATA_W  = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       dir_i,
    input  logic                       demand_i,
    input  logic [3:0]                 dack_i,
    input  logic                       ior_n_i,
    input  logic                       iow_n_i,
    input  logic                       eop_n_i,
    input  logic [DATA_W-1:0]          db_in_i,
    output logic [DATA_W-1:0]          db_out_o,
    output logic                       db_oe_o,
    output logic [3:0]                 dreq_o,
    input  logic                       loc_wr_valid_i,
    output logic                       loc_wr_ready_o,
    input  logic [DATA_W-1:0]          loc_wr_data_i,
    output logic                       loc_rd_valid_o,
    input  logic                       loc_rd_ready_i,
    output logic [DATA_W-1:0]          loc_rd_data_o,
    output logic [$clog2(DEPTH):0]     fifo_count_o,
    output logic                       tc_flag_o,
    output logic                       err_flag_o,
    input  logic                       flag_clr_i
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, REQ, ACK, DONE} state_t;

    state_t              state_q;
    logic                dir_q, dreq_q, strobe_q, tc_q, err_q;
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q, count_d;
    logic [DATA_W-1:0]   db_cap_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic ack, strobe, xfer_end, full, empty;
    logic loc_push, loc_pop, dma_push, dma_pop, push, pop;
    logic underrun, overflow, ready_now, ready_next, tc_set;
    logic [DATA_W-1:0] head, push_data;

    assign ack      = dack_i[CHANNEL];
    assign strobe   = dir_q ? !iow_n_i : !ior_n_i;
    assign xfer_end = strobe_q && !strobe;
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign head     = mem_q[rd_ptr_q];

    assign loc_push = !dir_q && loc_wr_valid_i && !full;
    assign loc_pop  =  dir_q && loc_rd_ready_i && !empty;
    assign dma_pop  = !dir_q && xfer_end && !empty;
    // A full FIFO still accepts a DMA byte when the local side drains one in the same cycle.
    assign dma_push =  dir_q && xfer_end && (!full || loc_pop);
    assign underrun = !dir_q && xfer_end && empty;
    assign overflow =  dir_q && xfer_end && full && !loc_pop;

    assign push      = loc_push || dma_push;
    assign pop       = loc_pop || dma_pop;
    assign push_data = dir_q ? db_cap_q : loc_wr_data_i;
    assign count_d   = count_q + CW'(push) - CW'(pop);

    assign ready_now  = dir_q ? !full : !empty;
    assign ready_next = dir_q ? (count_d != CW'(DEPTH)) : (count_d != '0);
    assign tc_set     = ack && !eop_n_i && (state_q == REQ || state_q == ACK);

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            dir_q    <= 1'b0;
            dreq_q   <= 1'b0;
            strobe_q <= 1'b0;
            tc_q     <= 1'b0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            db_cap_q <= '0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            // A strobe that began under ACK is tracked to its rising edge even if the FSM leaves ACK.
            strobe_q <= strobe && ((ack && state_q == ACK) || strobe_q);
            if (ack && strobe) db_cap_q <= db_in_i;

            if (tc_set)          tc_q <= 1'b1;
            else if (flag_clr_i) tc_q <= 1'b0;
            if (underrun || overflow) err_q <= 1'b1;
            else if (flag_clr_i)      err_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    dreq_q <= 1'b0;
                    dir_q  <= dir_i;
                    if (dir_i == dir_q && ready_now && !tc_q) state_q <= REQ;
                end
                REQ: begin
                    if (tc_set) begin
                        state_q <= DONE;
                        dreq_q  <= 1'b0;
                    end else if (!ready_now) begin
                        state_q <= IDLE;
                        dreq_q  <= 1'b0;
                    end else begin
                        dreq_q <= 1'b1;
                        if (ack) state_q <= ACK;
                    end
                end
                ACK: begin
                    if (tc_set) begin
                        state_q <= DONE;
                        dreq_q  <= 1'b0;
                    end else if (!ack) begin
                        state_q <= IDLE;
                        dreq_q  <= 1'b0;
                    end else if (demand_i) begin
                        dreq_q <= dreq_q && ready_next;
                    end else if (strobe) begin
                        dreq_q <= 1'b0;
                    end
                end
                DONE: begin
                    dreq_q <= 1'b0;
                    if (flag_clr_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_dreq
        assign dreq_o[gi] = (gi == CHANNEL) ? dreq_q : 1'b0;
    end

    assign db_oe_o        = (state_q == ACK) && ack && !ior_n_i && !dir_q;
    assign db_out_o       = (state_q == ACK && !dir_q) ? (empty ? '1 : head) : '0;
    assign loc_wr_ready_o = !dir_q && !full;
    assign loc_rd_valid_o = dir_q && !empty;
    assign loc_rd_data_o  = head;
    assign fifo_count_o   = count_q;
    assign tc_flag_o      = tc_q;
    assign err_flag_o     = err_q;
endmodule

// File: tb/tb_dma_io_peripheral.sv
// Directed bench for dma_io_peripheral on channel 2 with an 8-entry FIFO.
module tb_dma_io_peripheral;
    localparam int CH = 2;

    logic       clk = 1'b0;
    logic       rst_n, dir, demand, ior_n, iow_n, eop_n, flag_clr;
    logic [3:0] dack;
    logic [7:0] db_in, loc_wr_data;
    logic       loc_wr_valid, loc_rd_ready;
    logic [7:0] db_out, loc_rd_data;
    logic       db_oe, loc_wr_ready, loc_rd_valid, tc_flag, err_flag;
    logic [3:0] dreq;
    logic [3:0] fifo_count;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    dma_io_peripheral #(.CHANNEL(CH), .DEPTH(8), .DATA_W(8)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .dir_i(dir), .demand_i(demand),
        .dack_i(dack), .ior_n_i(ior_n), .iow_n_i(iow_n), .eop_n_i(eop_n),
        .db_in_i(db_in), .db_out_o(db_out), .db_oe_o(db_oe), .dreq_o(dreq),
        .loc_wr_valid_i(loc_wr_valid), .loc_wr_ready_o(loc_wr_ready), .loc_wr_data_i(loc_wr_data),
        .loc_rd_valid_o(loc_rd_valid), .loc_rd_ready_i(loc_rd_ready), .loc_rd_data_o(loc_rd_data),
        .fifo_count_o(fifo_count), .tc_flag_o(tc_flag), .err_flag_o(err_flag), .flag_clr_i(flag_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; dack = 4'b0; ior_n = 1'b1; iow_n = 1'b1; eop_n = 1'b1;
        loc_wr_valid = 1'b0; loc_rd_ready = 1'b0; flag_clr = 1'b0;
        db_in = 8'h00; loc_wr_data = 8'h00;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push_byte(input logic [7:0] d);
        loc_wr_valid = 1'b1; loc_wr_data = d;
        tick();
        loc_wr_valid = 1'b0;
    endtask

    task automatic wait_dreq(input string tag);
        int n = 0;
        while (dreq[CH] !== 1'b1 && n < 30) begin tick(); n++; end
        checks++;
        if (dreq[CH] !== 1'b1) $display("FAIL %s_dreq_wait got %b want 1", tag, dreq[CH]); else passed++;
    endtask

    task automatic test_reset();
        dir = 1'b0; demand = 1'b0;
        apply_reset();
        checks++; if (dreq !== 4'b0000) $display("FAIL reset_dreq got %b want 0000", dreq); else passed++;
        checks++; if (db_out !== 8'h00) $display("FAIL reset_db_out got %h want 00", db_out); else passed++;
        checks++; if (db_oe !== 1'b0) $display("FAIL reset_db_oe got %b want 0", db_oe); else passed++;
        checks++; if (fifo_count !== 4'd0) $display("FAIL reset_count got %0d want 0", fifo_count); else passed++;
        checks++; if ({tc_flag, err_flag} !== 2'b00) $display("FAIL reset_flags got %b want 00", {tc_flag, err_flag}); else passed++;
        checks++; if (loc_rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b want 0", loc_rd_valid); else passed++;
        checks++; if (loc_wr_ready !== 1'b1) $display("FAIL reset_wr_ready got %b want 1", loc_wr_ready); else passed++;
        $display("test_reset done");
    endtask

    task automatic test_single();
        dir = 1'b0; demand = 1'b0;
        apply_reset();
        push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3);
        wait_dreq("single");
        checks++; if (dreq !== 4'b0100) $display("FAIL single_dreq_bit got %b want 0100", dreq); else passed++;
        dack = 4'b0100; tick();
        ior_n = 1'b0; #1;
        checks++; if (db_oe !== 1'b1) $display("FAIL single_db_oe got %b want 1", db_oe); else passed++;
        checks++; if (db_out !== 8'hA1) $display("FAIL single_db_out got %h want a1", db_out); else passed++;
        tick();
        checks++; if (dreq !== 4'b0000) $display("FAIL single_dreq_drop got %b want 0000", dreq); else passed++;
        tick();
        ior_n = 1'b1; tick();
        checks++; if (fifo_count !== 4'd2) $display("FAIL single_count got %0d want 2", fifo_count); else passed++;
        dack = 4'b0; tick();
        $display("test_single done");
    endtask

    task automatic test_demand_read();
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hB0; exp_b[1] = 8'hB1; exp_b[2] = 8'hB2; exp_b[3] = 8'hB3;
        dir = 1'b0; demand = 1'b1;
        apply_reset();
        for (int i = 0; i < 4; i++) push_byte(exp_b[i]);
        wait_dreq("demand");
        dack = 4'b0100; tick();
        for (int i = 0; i < 4; i++) begin
            ior_n = 1'b0; #1;
            checks++; if (db_out !== exp_b[i]) $display("FAIL demand_db_out%0d got %h want %h", i, db_out, exp_b[i]); else passed++;
            tick(); tick();
            ior_n = 1'b1; tick();
            checks++;
            if (dreq[CH] !== (i < 3)) $display("FAIL demand_dreq%0d got %b want %b", i, dreq[CH], (i < 3)); else passed++;
        end
        checks++; if (fifo_count !== 4'd0) $display("FAIL demand_count got %0d want 0", fifo_count); else passed++;
        checks++; if (err_flag !== 1'b0) $display("FAIL demand_err got %b want 0", err_flag); else passed++;
        // one more IOR with the FIFO empty: underrun
        ior_n = 1'b0; #1;
        checks++; if (db_out !== 8'hFF) $display("FAIL underrun_db_out got %h want ff", db_out); else passed++;
        tick(); tick();
        ior_n = 1'b1; tick();
        checks++; if (err_flag !== 1'b1) $display("FAIL underrun_err got %b want 1", err_flag); else passed++;
        checks++; if (fifo_count !== 4'd0) $display("FAIL underrun_count got %0d want 0", fifo_count); else passed++;
        dack = 4'b0; tick();
        $display("test_demand_read done");
    endtask

    task automatic test_demand_write();
        logic [7:0] exp_d;
        dir = 1'b1; demand = 1'b1;
        apply_reset();
        wait_dreq("write");
        checks++; if (loc_wr_ready !== 1'b0) $display("FAIL write_wr_ready got %b want 0", loc_wr_ready); else passed++;
        dack = 4'b0100; tick();
        for (int i = 0; i < 8; i++) begin
            db_in = 8'h10 + 8'(i); iow_n = 1'b0;
            tick(); tick();
            iow_n = 1'b1; db_in = 8'h00; tick();
            checks++;
            if (dreq[CH] !== (i < 7)) $display("FAIL write_dreq%0d got %b want %b", i, dreq[CH], (i < 7)); else passed++;
        end
        checks++; if (fifo_count !== 4'd8) $display("FAIL write_count got %0d want 8", fifo_count); else passed++;
        // ninth byte into a full FIFO: overflow
        db_in = 8'h99; iow_n = 1'b0;
        tick(); tick();
        iow_n = 1'b1; tick();
        checks++; if (fifo_count !== 4'd8) $display("FAIL overflow_count got %0d want 8", fifo_count); else passed++;
        checks++; if (err_flag !== 1'b1) $display("FAIL overflow_err got %b want 1", err_flag); else passed++;
        dack = 4'b0; tick();
        loc_rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_d = 8'h10 + 8'(i);
            checks++;
            if (loc_rd_valid !== 1'b1 || loc_rd_data !== exp_d)
                $display("FAIL write_pop%0d got v=%b d=%h want v=1 d=%h", i, loc_rd_valid, loc_rd_data, exp_d);
            else passed++;
            tick();
        end
        loc_rd_ready = 1'b0;
        checks++; if (fifo_count !== 4'd0) $display("FAIL write_drain_count got %0d want 0", fifo_count); else passed++;
        $display("test_demand_write done");
    endtask

    task automatic test_eop();
        dir = 1'b0; demand = 1'b0;
        apply_reset();
        push_byte(8'hC0); push_byte(8'hC1); push_byte(8'hC2); push_byte(8'hC3); push_byte(8'hC4);
        wait_dreq("eop_first");
        dack = 4'b0100; tick();
        ior_n = 1'b0; tick(); tick();
        ior_n = 1'b1; tick();
        dack = 4'b0; tick();
        wait_dreq("eop_second");
        dack = 4'b0100; tick();
        ior_n = 1'b0; eop_n = 1'b0; #1;
        checks++; if (db_out !== 8'hC1) $display("FAIL eop_db_out got %h want c1", db_out); else passed++;
        tick();
        eop_n = 1'b1; tick();
        ior_n = 1'b1; tick();
        dack = 4'b0; tick();
        checks++; if (tc_flag !== 1'b1) $display("FAIL eop_tc got %b want 1", tc_flag); else passed++;
        checks++; if (fifo_count !== 4'd3) $display("FAIL eop_count got %0d want 3", fifo_count); else passed++;
        repeat (5) tick();
        checks++; if (dreq !== 4'b0000) $display("FAIL eop_dreq_held got %b want 0000", dreq); else passed++;
        flag_clr = 1'b1; tick();
        flag_clr = 1'b0;
        checks++; if (tc_flag !== 1'b0) $display("FAIL eop_tc_clr got %b want 0", tc_flag); else passed++;
        wait_dreq("eop_resume");
        $display("test_eop done");
    endtask

    task automatic test_back_to_back();
        dir = 1'b0; demand = 1'b1;
        apply_reset();
        push_byte(8'h31); push_byte(8'h32);
        wait_dreq("b2b");
        dack = 4'b0100; tick();
        ior_n = 1'b0; tick(); tick();
        ior_n = 1'b1; loc_wr_valid = 1'b1; loc_wr_data = 8'h33;
        tick();
        loc_wr_valid = 1'b0;
        checks++; if (fifo_count !== 4'd2) $display("FAIL b2b_count got %0d want 2", fifo_count); else passed++;
        ior_n = 1'b0; #1;
        checks++; if (db_out !== 8'h32) $display("FAIL b2b_db_out got %h want 32", db_out); else passed++;
        tick(); ior_n = 1'b1; tick();
        dack = 4'b0; tick();
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid_burst();
        dir = 1'b0; demand = 1'b1;
        apply_reset();
        push_byte(8'h41); push_byte(8'h42); push_byte(8'h43); push_byte(8'h44);
        wait_dreq("rst_mid");
        dack = 4'b0100; tick();
        ior_n = 1'b0; tick();
        rst_n = 1'b0; #1;
        checks++; if (dreq !== 4'b0000) $display("FAIL rst_mid_dreq got %b want 0000", dreq); else passed++;
        checks++; if (fifo_count !== 4'd0) $display("FAIL rst_mid_count got %0d want 0", fifo_count); else passed++;
        checks++; if (db_oe !== 1'b0) $display("FAIL rst_mid_db_oe got %b want 0", db_oe); else passed++;
        ior_n = 1'b1; dack = 4'b0; demand = 1'b0;
        tick();
        rst_n = 1'b1; tick();
        push_byte(8'h5A);
        wait_dreq("rst_recover");
        dack = 4'b0100; tick();
        ior_n = 1'b0; #1;
        checks++; if (db_out !== 8'h5A) $display("FAIL rst_recover_db_out got %h want 5a", db_out); else passed++;
        tick(); tick();
        ior_n = 1'b1; tick();
        checks++; if (fifo_count !== 4'd0) $display("FAIL rst_recover_count got %0d want 0", fifo_count); else passed++;
        dack = 4'b0; tick();
        $display("test_reset_mid_burst done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_demand_read();
        test_demand_write();
        test_eop();
        test_back_to_back();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
